ifetch_responder: RTL and testbench

- Responder side of the PC fetch-request interface. Accepts one fetch request per cycle (enable, byte PC, word address) from the PC stage and drives the synchronous-read instruction BRAM (fixed 1-cycle read latency).
- Buffers returned words with their PC in a small FIFO and presents them to decode on a valid/ready handshake.
- Drives the PC stage's stall input for backpressure, and discards in-flight or buffered fetches on a jump flush.

---
 rtl/ifetch_responder.sv | 108 ++++++++++
 tb/tb_ifetch_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: issues BRAM reads for PC-stage requests and queues the
// returned words with their PCs for decode, with conservative stall and jump flush.
module ifetch_responder #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_en,
  input  logic [31:0]       req_pc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  input  logic [31:0]       mem_rdata,
  input  logic              dec_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             infl_v_r;
  logic [31:0]      infl_pc_r;
  logic [31:0]      data_r [DEPTH];
  logic [31:0]      pc_r   [DEPTH];

  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             stall_s;
  logic             valid_s;
  logic [CNT_W:0]   occ_s;

  // Stall counts the in-flight read as occupied, so a return always has a free slot.
  always_comb begin
    occ_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, infl_v_r};
    stall_s = (occ_s >= DEPTH_C);
    valid_s = (count_r != {CNT_W{1'b0}});
    issue_s = req_en & ~stall_s & ~flush & reset;
    push_s  = infl_v_r & ~flush;
    pop_s   = valid_s & dec_ready & ~flush;
  end

  assign mem_en      = issue_s;
  assign mem_addr    = req_addr;
  assign stall       = stall_s;
  assign instr_valid = valid_s;
  assign instr       = data_r[rd_ptr_r];
  assign instr_pc    = pc_r[rd_ptr_r];

  // Tracks the single outstanding BRAM read and the PC it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      infl_v_r  <= 1'b0;
      infl_pc_r <= 32'h0000_0000;
    end else begin
      infl_v_r  <= issue_s;
      infl_pc_r <= req_pc;
    end
  end

  // FIFO occupancy and pointers; a flush empties the queue and overrides any pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (flush) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: returned word paired with the PC captured at issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= 32'h0000_0000;
        pc_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_r[wr_ptr_r] <= mem_rdata;
      pc_r[wr_ptr_r]   <= infl_pc_r;
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: a DEPTH=2 and a DEPTH=4 instance share the
// request stimulus, each with its own 1-cycle BRAM model (word n = 0xA000_0000 + n).
module tb_ifetch_responder;
  logic        clk, reset, req_en, flush, dec_ready;
  logic [31:0] req_pc;
  logic [12:0] req_addr;
  logic [31:0] rdata2, rdata4, instr2, instr4, ipc2, ipc4;
  logic [12:0] maddr2, maddr4;
  logic        men2, men4, stall2, stall4, v2, v4;
  int          n_vec, n_err;

  assign req_addr = req_pc[14:2];

  ifetch_responder #(.ADDR_W(13), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_en(req_en), .req_pc(req_pc), .req_addr(req_addr),
    .flush(flush), .mem_rdata(rdata2), .dec_ready(dec_ready), .mem_en(men2),
    .mem_addr(maddr2), .stall(stall2), .instr_valid(v2), .instr(instr2), .instr_pc(ipc2));

  ifetch_responder #(.ADDR_W(13), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_en(req_en), .req_pc(req_pc), .req_addr(req_addr),
    .flush(flush), .mem_rdata(rdata4), .dec_ready(dec_ready), .mem_en(men4),
    .mem_addr(maddr4), .stall(stall4), .instr_valid(v4), .instr(instr4), .instr_pc(ipc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (men2) rdata2 <= 32'hA000_0000 + {19'd0, maddr2};
  always @(posedge clk) if (men4) rdata4 <= 32'hA000_0000 + {19'd0, maddr4};

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    req_en = 1'b0; flush = 1'b1; dec_ready = 1'b0;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_en = 1'b1; req_pc = 32'h0; flush = 1'b0; dec_ready = 1'b0;
    cyc(); cyc(); #1;
    n_vec++; if (men2 !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", men2); end
    n_vec++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall2); end
    n_vec++; if (v2 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", v2); end
    n_vec++; if (instr2 !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr2); end
    n_vec++; if (ipc2 !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", ipc2); end
    n_vec++; if (men4 !== 1'b0) begin n_err++; $display("FAIL reset_mem_en4: got %b want 0", men4); end
    reset = 1'b1; req_en = 1'b0;
    cyc();
  endtask

  // DEPTH=4 keeps one word per cycle flowing with no stall.
  task automatic test_streaming();
    logic [31:0] pc;
    pc = 32'h0;
    for (int c = 0; c < 10; c++) begin
      req_en = (c < 8); req_pc = pc; dec_ready = 1'b1; #1;
      n_vec++; if (stall4 !== 1'b0) begin n_err++; $display("FAIL stream_stall c%0d: got %b want 0", c, stall4); end
      n_vec++; if (v4 !== (c >= 2)) begin n_err++; $display("FAIL stream_valid c%0d: got %b want %b", c, v4, (c >= 2)); end
      if (c >= 2) begin
        n_vec++; if (instr4 !== 32'hA000_0000 + 32'(c - 2)) begin n_err++; $display("FAIL stream_instr c%0d: got %h want %h", c, instr4, 32'hA000_0000 + 32'(c - 2)); end
        n_vec++; if (ipc4 !== 32'((c - 2) * 4)) begin n_err++; $display("FAIL stream_pc c%0d: got %h want %h", c, ipc4, 32'((c - 2) * 4)); end
      end
      if (men4) pc = pc + 32'h4;
      cyc();
    end
  endtask

  task automatic run_table(input int n, input logic [31:0] base, input logic [31:0] last,
                           input int rdy_from, input logic [0:9] e_st, input logic [0:9] e_me,
                           input logic [0:9] e_v, input logic [31:0] e_pc [10], input string nm);
    logic [31:0] pc;
    pc = base;
    for (int c = 0; c < n; c++) begin
      req_en = (pc <= last); req_pc = pc; dec_ready = (c >= rdy_from); #1;
      n_vec++; if (stall2 !== e_st[c]) begin n_err++; $display("FAIL %s_stall c%0d: got %b want %b", nm, c, stall2, e_st[c]); end
      n_vec++; if (men2 !== e_me[c]) begin n_err++; $display("FAIL %s_mem_en c%0d: got %b want %b", nm, c, men2, e_me[c]); end
      n_vec++; if (v2 !== e_v[c]) begin n_err++; $display("FAIL %s_valid c%0d: got %b want %b", nm, c, v2, e_v[c]); end
      if (e_v[c]) begin
        n_vec++; if (ipc2 !== e_pc[c]) begin n_err++; $display("FAIL %s_pc c%0d: got %h want %h", nm, c, ipc2, e_pc[c]); end
        n_vec++; if (instr2 !== 32'hA000_0000 + (e_pc[c] >> 2)) begin n_err++; $display("FAIL %s_instr c%0d: got %h want %h", nm, c, instr2, 32'hA000_0000 + (e_pc[c] >> 2)); end
      end
      if (men2) pc = pc + 32'h4;
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e_pc [10];
    e_pc = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0};
    run_table(10, 32'h0, 32'h8, 5, 10'b0011110000, 10'b1100001000, 10'b0011111010, e_pc, "bp");
  endtask

  task automatic test_push_pop();
    logic [31:0] e_pc [10];
    e_pc = '{32'h0, 32'h0, 32'h100, 32'h104, 32'h0, 32'h108, 32'h0, 32'h0, 32'h0, 32'h0};
    run_table(7, 32'h100, 32'h108, 0, 10'b0010000000, 10'b1101000000, 10'b0011010000, e_pc, "pp");
  endtask

  task automatic test_flush();
    logic [31:0] pc;
    pc = 32'h0;
    for (int c = 0; c < 3; c++) begin
      req_en = 1'b1; req_pc = pc; dec_ready = 1'b0; #1;
      if (men4) pc = pc + 32'h4;
      cyc();
    end
    flush = 1'b1; req_en = 1'b1; req_pc = 32'h40; #1;
    n_vec++; if (men4 !== 1'b0) begin n_err++; $display("FAIL flush_mem_en: got %b want 0", men4); end
    n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", v4); end
    n_vec++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall2: got %b want 1", stall2); end
    cyc();
    flush = 1'b0; dec_ready = 1'b1; #1;
    n_vec++; if (v4 !== 1'b0) begin n_err++; $display("FAIL flush_post_valid: got %b want 0", v4); end
    n_vec++; if (stall4 !== 1'b0) begin n_err++; $display("FAIL flush_post_stall: got %b want 0", stall4); end
    n_vec++; if (men4 !== 1'b1) begin n_err++; $display("FAIL flush_target_issue: got %b want 1", men4); end
    n_vec++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL flush_post_stall2: got %b want 0", stall2); end
    n_vec++; if (v2 !== 1'b0) begin n_err++; $display("FAIL flush_post_valid2: got %b want 0", v2); end
    cyc();
    req_en = 1'b0; #1;
    n_vec++; if (v4 !== 1'b0) begin n_err++; $display("FAIL flush_c5_valid: got %b want 0", v4); end
    cyc(); #1;
    n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL flush_target_valid: got %b want 1", v4); end
    n_vec++; if (ipc4 !== 32'h40) begin n_err++; $display("FAIL flush_target_pc: got %h want 40", ipc4); end
    n_vec++; if (instr4 !== 32'hA000_0010) begin n_err++; $display("FAIL flush_target_instr: got %h want a0000010", instr4); end
    n_vec++; if (ipc2 !== 32'h40) begin n_err++; $display("FAIL flush_target_pc2: got %h want 40", ipc2); end
    cyc(); #1;
    n_vec++; if (v4 !== 1'b0) begin n_err++; $display("FAIL flush_no_stale: got %b want 0", v4); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc;
    pc = 32'h200;
    for (int c = 0; c < 4; c++) begin
      req_en = 1'b1; req_pc = pc; dec_ready = 1'b0; #1;
      if (men4) pc = pc + 32'h4;
      cyc();
    end
    req_pc = pc; #1;
    n_vec++; if (stall4 !== 1'b1) begin n_err++; $display("FAIL rmid_full_stall: got %b want 1", stall4); end
    #2 reset = 1'b0; #1;
    n_vec++; if (v4 !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", v4); end
    n_vec++; if (stall4 !== 1'b0) begin n_err++; $display("FAIL rmid_stall: got %b want 0", stall4); end
    n_vec++; if (men4 !== 1'b0) begin n_err++; $display("FAIL rmid_mem_en: got %b want 0", men4); end
    n_vec++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rmid_valid2: got %b want 0", v2); end
    cyc();
    #2 reset = 1'b1; req_en = 1'b0;
    cyc();
    req_en = 1'b1; req_pc = 32'h0; dec_ready = 1'b1;
    cyc();
    req_en = 1'b0;
    cyc(); #1;
    n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL rmid_first_valid: got %b want 1", v4); end
    n_vec++; if (instr4 !== 32'hA000_0000) begin n_err++; $display("FAIL rmid_first_instr: got %h want a0000000", instr4); end
    n_vec++; if (ipc4 !== 32'h0) begin n_err++; $display("FAIL rmid_first_pc: got %h want 0", ipc4); end
    n_vec++; if (instr2 !== 32'hA000_0000) begin n_err++; $display("FAIL rmid_first_instr2: got %h want a0000000", instr2); end
    cyc(); #1;
    n_vec++; if (v4 !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale: got %b want 0", v4); end
    cyc();
  endtask

  task automatic test_wrap();
    dec_ready = 1'b1; req_en = 1'b1; req_pc = 32'h7FFC; #1;
    n_vec++; if (maddr2 !== 13'h1FFF) begin n_err++; $display("FAIL wrap_addr0: got %h want 1fff", maddr2); end
    n_vec++; if (men2 !== 1'b1) begin n_err++; $display("FAIL wrap_en0: got %b want 1", men2); end
    cyc();
    req_pc = 32'h8000; #1;
    n_vec++; if (maddr2 !== 13'h0000) begin n_err++; $display("FAIL wrap_addr1: got %h want 0000", maddr2); end
    n_vec++; if (men2 !== 1'b1) begin n_err++; $display("FAIL wrap_en1: got %b want 1", men2); end
    cyc();
    req_en = 1'b0; #1;
    n_vec++; if (ipc2 !== 32'h7FFC) begin n_err++; $display("FAIL wrap_pc0: got %h want 7ffc", ipc2); end
    n_vec++; if (instr2 !== 32'hA000_1FFF) begin n_err++; $display("FAIL wrap_instr0: got %h want a0001fff", instr2); end
    cyc(); #1;
    n_vec++; if (ipc2 !== 32'h8000) begin n_err++; $display("FAIL wrap_pc1: got %h want 8000", ipc2); end
    n_vec++; if (instr2 !== 32'hA000_0000) begin n_err++; $display("FAIL wrap_instr1: got %h want a0000000", instr2); end
    cyc(); #1;
    n_vec++; if (v2 !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b want 0", v2); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_streaming();
    clear();
    test_backpressure();
    clear();
    test_push_pop();
    clear();
    test_flush();
    clear();
    test_reset_mid();
    clear();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
